multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the CPU datapath. Accepts one instruction word at a time over a valid/ready handshake and decodes it. Drives the immediate extender's control lines (extend_IMM, extend_shamt, zero_ext_IMM) plus ALU-source, memory and register-write strobes. Steps the instruction through DECODE/EXEC/MEM/WB and counts retired instructions.

Parameters:
MEM_TIMEOUT, 255, max cycles in MEM waiting for mem_ready before abort (1..65535)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
ir_valid  input  1  instruction word on IR is valid
ir_ready  output  1  controller can accept an instruction
IR  input  32  instruction word
mem_ready  input  1  data memory completed access
extend_IMM  output  1  extender selects IR[15:0]
extend_shamt  output  1  extender selects IR[10:6]
zero_ext_IMM  output  1  zero- (1) vs sign-extend (0) of IR[15:0]
alu_src_imm  output  1  ALU operand B from extender
mem_read  output  1  load access in progress
mem_write  output  1  store access in progress
reg_write  output  1  register-file write strobe (1 cycle)
halt  output  1  syscall reached; sticky until reset
illegal  output  1  1-cycle pulse, undecodable instruction
mem_err  output  1  1-cycle pulse, MEM timeout
retired_cnt  output  CNT_W  instructions completed

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, latched IR=0, all control outputs 0, halt=0, timeout counter=0, retired_cnt=0. ir_ready=0 while rst_n=0.
- States: IDLE, DECODE, EXEC, MEM, WB, HALT.
- IDLE: ir_ready=1. ir_valid&ir_ready at edge latches IR -> DECODE. Otherwise stay.
- DECODE (1 cycle): register extender/ALU controls from the latched IR. They are visible from the first EXEC cycle and held until the next DECODE.
  - Zero-extend (extend_IMM=1, zero_ext_IMM=1, alu_src_imm=1): opcode 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui.
  - Sign-extend (extend_IMM=1, zero_ext_IMM=0, alu_src_imm=1): 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu, 0x23 lw, 0x2B sw.
  - Sign-extend, alu_src_imm=0: 0x04 beq, 0x05 bne.
  - opcode 0x00 funct 0x00/0x02/0x03 (sll/srl/sra): extend_shamt=1, extend_IMM=0, alu_src_imm=1.
  - All other opcode 0x00 (R-type, incl. syscall funct 0x0C): extend_IMM=0, extend_shamt=0. The extender then outputs constant 10, the syscall compare value.
  - Anything else: illegal.
- EXEC (1 cycle):
  - lw/sw -> MEM.
  - beq/bne -> IDLE, retire.
  - syscall -> HALT, retire.
  - illegal -> IDLE, illegal pulse, no retire.
  - all others -> WB.
- MEM: mem_read=1 (lw) or mem_write=1 (sw), held until exit. The timeout counter increments each MEM cycle.
  - mem_ready=1: lw -> WB; sw -> IDLE, retire. Counter clears.
  - Counter reaches MEM_TIMEOUT with mem_ready still 0: mem_err pulse, strobes drop, -> IDLE, no retire, counter clears.
  - mem_ready on the same edge the counter hits MEM_TIMEOUT counts as success.
- WB: reg_write=1 exactly one cycle -> IDLE, retire.
- HALT: halt=1, ir_ready=0, all strobes 0. Stays until reset.
- Retire: retired_cnt+1 on the edge leaving the final state. Wraps modulo 2^CNT_W.
- ir_valid outside IDLE is ignored; IR is not re-sampled.
- Latency, accept edge to IDLE re-entry: ALU/shift 4 cycles, branch 3, sw 3+N, lw 4+N, where N is MEM wait cycles (N≥1).
- Reset asserted in any state, including mid-MEM: next edge returns to the full reset values. No retire, no error pulse.

Test Plan:
- addi IR=0x2008FFFF after reset -> ir_ready drops the cycle after accept; EXEC: extend_IMM=1, zero_ext_IMM=0, alu_src_imm=1; reg_write pulse in cycle 3; retired_cnt=1.
- andi 0x3108FFFF then sll 0x00084080 -> first: zero_ext_IMM=1; second: extend_shamt=1, extend_IMM=0; retired_cnt=2.
- lw 0x8D090004 with mem_ready after 3 cycles -> mem_read high exactly 3 cycles, then reg_write pulse; sw 0xAD090004 -> mem_write, no reg_write; both retire.
- MEM_TIMEOUT=4, lw, mem_ready held 0 -> mem_err pulse after 4 MEM cycles, back to IDLE, retired_cnt unchanged; repeat with mem_ready at cycle 4 -> success.
- syscall 0x0000000C -> extend_IMM=extend_shamt=0; halt=1; ir_ready stays 0 despite ir_valid; rst_n=0 clears halt.
- opcode 0x3F -> illegal pulse in EXEC, no retire. Reset asserted mid-MEM -> all outputs 0 next edge, retired_cnt=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle control FSM for the CPU datapath. One instruction word is
// accepted at a time over a valid/ready handshake, decoded, and stepped
// through DECODE / EXEC / MEM / WB. The controller drives the immediate
// extender's select lines, the ALU operand-B source, the data-memory
// strobes and the register-file write strobe, and it counts retired
// instructions.
//
// Parameters
//   MEM_TIMEOUT : max MEM cycles waiting for mem_ready before abort (1..65535)
//   CNT_W       : width of the retired-instruction counter
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   ir_valid/ir_ready : instruction handshake, IR is the 32-bit word
//   mem_ready         : data memory finished the current access
//   extend_IMM        : extender selects IR[15:0]
//   extend_shamt      : extender selects IR[10:6]
//   zero_ext_IMM      : zero- (1) or sign- (0) extension of IR[15:0]
//   alu_src_imm       : ALU operand B comes from the extender
//   mem_read/write    : load/store access in progress
//   reg_write         : one-cycle register-file write strobe
//   halt              : syscall reached, sticky until reset
//   illegal, mem_err  : one-cycle error pulses
//   retired_cnt       : number of completed instructions (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ir_valid,
  output logic             ir_ready,
  input  logic [31:0]      IR,
  input  logic             mem_ready,
  output logic             extend_IMM,
  output logic             extend_shamt,
  output logic             zero_ext_IMM,
  output logic             alu_src_imm,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             halt,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [15:0]      TMO_LIMIT = 16'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state_q, state_d;
  logic [31:0]        ir_q, ir_d;
  logic               ext_imm_q, ext_imm_d;
  logic               ext_shamt_q, ext_shamt_d;
  logic               zero_ext_q, zero_ext_d;
  logic               alu_src_q, alu_src_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [15:0]        tmo_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_err_q, mem_err_d;

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               dec_ext_imm;
  logic               dec_ext_shamt;
  logic               dec_zero_ext;
  logic               dec_alu_src;
  logic               dec_lw;
  logic               dec_sw;
  logic               dec_branch;
  logic               dec_syscall;
  logic               dec_illegal;

  // The operand fields of the word are consumed by the datapath's own copy
  // of IR; the controller only looks at opcode and funct.
  logic               unused_ir_bits;
  assign unused_ir_bits = ^ir_q[25:6];

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];

  // Instruction decode from the latched word. Because the latched word only
  // changes on accept, these flags are stable for the whole instruction and
  // can steer EXEC and MEM directly.
  always_comb begin
    dec_ext_imm   = 1'b0;
    dec_ext_shamt = 1'b0;
    dec_zero_ext  = 1'b0;
    dec_alu_src   = 1'b0;
    dec_lw        = 1'b0;
    dec_sw        = 1'b0;
    dec_branch    = 1'b0;
    dec_syscall   = 1'b0;
    dec_illegal   = 1'b0;
    case (opcode)
      6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dec_ext_imm  = 1'b1;
        dec_zero_ext = 1'b1;
        dec_alu_src  = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        dec_ext_imm = 1'b1;
        dec_alu_src = 1'b1;
      end
      6'h23: begin
        dec_ext_imm = 1'b1;
        dec_alu_src = 1'b1;
        dec_lw      = 1'b1;
      end
      6'h2B: begin
        dec_ext_imm = 1'b1;
        dec_alu_src = 1'b1;
        dec_sw      = 1'b1;
      end
      6'h04, 6'h05: begin
        dec_ext_imm = 1'b1;
        dec_branch  = 1'b1;
      end
      6'h00: begin
        // Non-shift R-types leave both extender selects low so the
        // extender emits its constant 10 for the syscall comparison.
        if (funct == 6'h00 || funct == 6'h02 || funct == 6'h03) begin
          dec_ext_shamt = 1'b1;
          dec_alu_src   = 1'b1;
        end else if (funct == 6'h0C) begin
          dec_syscall = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Next-state logic. Retirement is applied on the transition out of the
  // instruction's final state; errors and aborts never retire.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    ext_imm_d   = ext_imm_q;
    ext_shamt_d = ext_shamt_q;
    zero_ext_d  = zero_ext_q;
    alu_src_d   = alu_src_q;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;
    mem_err_d   = 1'b0;
    tmo_inc     = tmo_q + 16'd1;
    case (state_q)
      ST_IDLE: begin
        if (ir_valid) begin
          ir_d    = IR;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ext_imm_d   = dec_ext_imm;
        ext_shamt_d = dec_ext_shamt;
        zero_ext_d  = dec_zero_ext;
        alu_src_d   = dec_alu_src;
        state_d     = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_illegal) begin
          state_d = ST_IDLE;
        end else if (dec_lw || dec_sw) begin
          state_d = ST_MEM;
        end else if (dec_branch) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q + CNT_ONE;
        end else if (dec_syscall) begin
          state_d = ST_HALT;
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // tmo_inc counts the current MEM cycle, so a ready arriving in the
        // last allowed cycle still wins over the timeout.
        if (mem_ready) begin
          tmo_d = 16'd0;
          if (dec_lw) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else if (tmo_inc == TMO_LIMIT) begin
          tmo_d     = 16'd0;
          mem_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
        cnt_d   = cnt_q + CNT_ONE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ir_q        <= 32'd0;
      ext_imm_q   <= 1'b0;
      ext_shamt_q <= 1'b0;
      zero_ext_q  <= 1'b0;
      alu_src_q   <= 1'b0;
      tmo_q       <= 16'd0;
      cnt_q       <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ext_imm_q   <= ext_imm_d;
      ext_shamt_q <= ext_shamt_d;
      zero_ext_q  <= zero_ext_d;
      alu_src_q   <= alu_src_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // Strobes are pure functions of the registered state and the stable
  // decode, so they drop together on the edge that leaves the state.
  assign ir_ready     = rst_n && (state_q == ST_IDLE);
  assign extend_IMM   = ext_imm_q;
  assign extend_shamt = ext_shamt_q;
  assign zero_ext_IMM = zero_ext_q;
  assign alu_src_imm  = alu_src_q;
  assign mem_read     = (state_q == ST_MEM) && dec_lw;
  assign mem_write    = (state_q == ST_MEM) && dec_sw;
  assign reg_write    = (state_q == ST_WB);
  assign halt         = (state_q == ST_HALT);
  assign illegal      = (state_q == ST_EXEC) && dec_illegal;
  assign mem_err      = mem_err_q;
  assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Bench for multicycle_ctrl with MEM_TIMEOUT=4. Each directed instruction
// pushes its hand-computed expected behaviour into a queue; an independent
// monitor tracks every accepted instruction until it completes (back to
// IDLE or into HALT) and compares what it observed with the queue head.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  typedef struct {
    logic [31:0] ir;
    int          lat;
    logic [3:0]  ctrl;
    int          rd;
    int          wr;
    int          rw;
    int          ill;
    int          err;
    logic [31:0] ret;
    logic        halt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] IR;
  logic        mem_ready;
  logic        extend_IMM;
  logic        extend_shamt;
  logic        zero_ext_IMM;
  logic        alu_src_imm;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        halt;
  logic        illegal;
  logic        mem_err;
  logic [31:0] retired_cnt;
  logic [9:0]  outs;

  int   checks;
  int   failures;
  int   completions;
  exp_t exp_q[$];

  int         mon_busy;
  int         mon_lat;
  int         mon_rd;
  int         mon_wr;
  int         mon_rw;
  int         mon_ill;
  int         mon_err;
  logic [3:0] mon_ctrl;

  multicycle_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .IR(IR),
    .mem_ready(mem_ready),
    .extend_IMM(extend_IMM),
    .extend_shamt(extend_shamt),
    .zero_ext_IMM(zero_ext_IMM),
    .alu_src_imm(alu_src_imm),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .reg_write(reg_write),
    .halt(halt),
    .illegal(illegal),
    .mem_err(mem_err),
    .retired_cnt(retired_cnt)
  );

  assign outs = {extend_IMM, extend_shamt, zero_ext_IMM, alu_src_imm,
                 mem_read, mem_write, reg_write, halt, illegal, mem_err};

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, reports it when it differs.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue the expectation, present the word until accepted, then answer
  // memory accesses with mem_ready in the mem_wait-th access cycle
  // (0 = never) until the monitor reports completion.
  task automatic applyStimulus(input logic [31:0] ir, input int mem_wait,
                               input int lat, input logic [3:0] ctrl,
                               input int rd, input int wr, input int rw,
                               input int ill, input int err,
                               input logic [31:0] ret, input logic halt_exp);
    exp_t e;
    int   start;
    int   k;
    bit   got;
    e.ir = ir; e.lat = lat; e.ctrl = ctrl; e.rd = rd; e.wr = wr;
    e.rw = rw; e.ill = ill; e.err = err; e.ret = ret; e.halt = halt_exp;
    exp_q.push_back(e);
    start = completions;
    @(posedge clk); #1;
    IR = ir;
    ir_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ir_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept ir=%h: ir_ready never 1, required 1", ir);
      ir_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ir_valid = 1'b0;
    IR = 32'hFC000000;
    k = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_read || mem_write) k++;
      mem_ready = (mem_read || mem_write) && (k == mem_wait);
      if (completions != start) begin
        got = 1'b1;
        break;
      end
    end
    mem_ready = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL complete ir=%h: no completion, required one", ir);
    end
  endtask

  // Monitor: follows each accepted instruction and scores it on completion.
  initial begin
    exp_t e;
    mon_busy = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_busy = 0;
      end else if (mon_busy == 0) begin
        if (ir_valid && ir_ready) begin
          mon_busy = 1;
          mon_lat = 0; mon_rd = 0; mon_wr = 0; mon_rw = 0;
          mon_ill = 0; mon_err = 0; mon_ctrl = 4'h0;
        end
      end else begin
        mon_lat++;
        if (mem_read)  mon_rd++;
        if (mem_write) mon_wr++;
        if (reg_write) mon_rw++;
        if (illegal)   mon_ill++;
        if (mem_err)   mon_err++;
        if (mon_lat == 2)
          mon_ctrl = {extend_IMM, extend_shamt, zero_ext_IMM, alu_src_imm};
        if (ir_ready || halt) begin
          mon_busy = 0;
          completions++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard: completion with empty queue, required none");
          end else begin
            e = exp_q.pop_front();
            checkOutput($sformatf("latency ir=%h", e.ir), 32'(mon_lat), 32'(e.lat));
            checkOutput($sformatf("ctrl ir=%h", e.ir), 32'(mon_ctrl), 32'(e.ctrl));
            checkOutput($sformatf("mem_read_cyc ir=%h", e.ir), 32'(mon_rd), 32'(e.rd));
            checkOutput($sformatf("mem_write_cyc ir=%h", e.ir), 32'(mon_wr), 32'(e.wr));
            checkOutput($sformatf("reg_write_cyc ir=%h", e.ir), 32'(mon_rw), 32'(e.rw));
            checkOutput($sformatf("illegal_cyc ir=%h", e.ir), 32'(mon_ill), 32'(e.ill));
            checkOutput($sformatf("mem_err_cyc ir=%h", e.ir), 32'(mon_err), 32'(e.err));
            checkOutput($sformatf("retired ir=%h", e.ir), retired_cnt, e.ret);
            checkOutput($sformatf("halt ir=%h", e.ir), 32'(halt), 32'(e.halt));
          end
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    bit seen;
    checks = 0;
    failures = 0;
    completions = 0;
    rst_n = 1'b0;
    ir_valid = 1'b0;
    IR = 32'd0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ir_ready", 32'(ir_ready), 32'd0);
    checkOutput("reset_outs", 32'(outs), 32'd0);
    checkOutput("reset_retired", retired_cnt, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_ir_ready", 32'(ir_ready), 32'd1);

    //            IR            wait lat ctrl    rd wr rw il er ret halt
    applyStimulus(32'h2008FFFF, 0,   4,  4'b1001, 0, 0, 1, 0, 0, 1,  0); // addi
    applyStimulus(32'h3108FFFF, 0,   4,  4'b1011, 0, 0, 1, 0, 0, 2,  0); // andi
    applyStimulus(32'h00084080, 0,   4,  4'b0101, 0, 0, 1, 0, 0, 3,  0); // sll
    applyStimulus(32'h8D090004, 3,   7,  4'b1001, 3, 0, 1, 0, 0, 4,  0); // lw
    applyStimulus(32'hAD090004, 2,   5,  4'b1001, 0, 2, 0, 0, 0, 5,  0); // sw
    applyStimulus(32'h8D090004, 0,   7,  4'b1001, 4, 0, 0, 0, 1, 5,  0); // lw timeout
    applyStimulus(32'h8D090004, 4,   8,  4'b1001, 4, 0, 1, 0, 0, 6,  0); // lw ready at limit
    applyStimulus(32'h11090003, 0,   3,  4'b1000, 0, 0, 0, 0, 0, 7,  0); // beq
    applyStimulus(32'h15090003, 0,   3,  4'b1000, 0, 0, 0, 0, 0, 8,  0); // bne
    applyStimulus(32'h3508ABCD, 0,   4,  4'b1011, 0, 0, 1, 0, 0, 9,  0); // ori
    applyStimulus(32'h01095020, 0,   4,  4'b0000, 0, 0, 1, 0, 0, 10, 0); // add
    applyStimulus(32'h00084083, 0,   4,  4'b0101, 0, 0, 1, 0, 0, 11, 0); // sra
    applyStimulus(32'hFC000000, 0,   3,  4'b0000, 0, 0, 0, 1, 0, 11, 0); // illegal
    applyStimulus(32'h3C081234, 0,   4,  4'b1011, 0, 0, 1, 0, 0, 12, 0); // lui
    applyStimulus(32'h2908FFFF, 0,   4,  4'b1001, 0, 0, 1, 0, 0, 13, 0); // slti
    applyStimulus(32'h0000000C, 0,   3,  4'b0000, 0, 0, 0, 0, 0, 14, 1); // syscall

    // HALT must ignore a valid word and hold until reset.
    IR = 32'h2008FFFF;
    ir_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("halt_ir_ready", 32'(ir_ready), 32'd0);
      checkOutput("halt_sticky", 32'(halt), 32'd1);
    end
    checkOutput("halt_retired", retired_cnt, 32'd14);
    @(posedge clk); #1;
    rst_n = 1'b0;
    ir_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("halt_reset_outs", 32'(outs), 32'd0);
    checkOutput("halt_reset_retired", retired_cnt, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("after_halt_ir_ready", 32'(ir_ready), 32'd1);

    applyStimulus(32'h2008FFFF, 0, 4, 4'b1001, 0, 0, 1, 0, 0, 1, 0); // addi

    // Reset in the middle of a load: everything back to reset values.
    @(posedge clk); #1;
    IR = 32'h8D090004;
    ir_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ir_ready) break;
    end
    @(posedge clk); #1;
    ir_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_read) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("midmem_read", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midmem_reset_outs", 32'(outs), 32'd0);
    checkOutput("midmem_reset_retired", retired_cnt, 32'd0);
    checkOutput("midmem_reset_ir_ready", 32'(ir_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midmem_after_mem_err", 32'(mem_err), 32'd0);
    checkOutput("midmem_after_ir_ready", 32'(ir_ready), 32'd1);

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
